inst_mem_loader: RTL and testbench

//  Write-side companion of the byte-addressed instruction memory. Accepts 32-bit

---
 rtl/inst_mem_loader.sv | 141 ++++++++++++++
 tb/tb_inst_mem_loader.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/inst_mem_loader.sv
// Instruction-memory preload engine: takes 32-bit words over valid/ready and
// writes each as four little-endian bytes, one per clock, to the byte port.

// Per-byte lane: drives its slice of the latched word when idx points at it,
// zero otherwise, so the top can OR the lanes into the single byte port.
module inst_mem_loader_lane #(
  parameter int VEC_W = 8,
  parameter int IDX_W = 2,
  parameter int LANE  = 0
) (
  input  logic [IDX_W-1:0] idx,
  input  logic [VEC_W-1:0] data,
  output logic [VEC_W-1:0] sel_byte
);
  assign sel_byte = (idx == IDX_W'(LANE)) ? data : '0;
endmodule

module inst_mem_loader #(
  parameter int MEM_BYTES = 96,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Load_Start,
  input  logic [63:0]      Load_Base,
  input  logic             Word_Valid,
  input  logic [31:0]      Word_Data,
  input  logic             Word_Last,
  output logic             Word_Ready,
  output logic             Mem_Wr_En,
  output logic [63:0]      Mem_Wr_Addr,
  output logic [7:0]       Mem_Wr_Byte,
  output logic             Load_Busy,
  output logic             Load_Done,
  output logic             Load_Error,
  output logic [CNT_W-1:0] Words_Loaded
);
  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 8;
  localparam int IDX_W     = 2;

  typedef enum logic [1:0] {IDLE, ACCEPT, WRITE, DONE} state_t;

  typedef struct packed {
    logic [NUM_LANES-1:0][VEC_W-1:0] data;
    logic                            last;
  } word_t;

  state_t                          state, state_nxt;
  word_t                           word_q;
  logic [63:0]                     addr;
  logic [IDX_W-1:0]                idx;
  logic [64:0]                     end_addr;
  logic                            fits;
  logic                            misaligned;
  logic [NUM_LANES-1:0][VEC_W-1:0] lane_byte;

  // 65-bit sum so a base near 2^64 cannot wrap into a "fitting" address.
  assign end_addr   = {1'b0, addr} + 65'd4;
  assign fits       = (end_addr <= 65'(MEM_BYTES));
  assign misaligned = |Load_Base[1:0];

  // State register; reset drops straight to IDLE, aborting any write burst.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: start/align check, handshake/bounds check, 4-byte burst, done pulse.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (Load_Start) state_nxt = misaligned ? DONE : ACCEPT;
      ACCEPT:  if (Word_Valid) state_nxt = fits ? WRITE : DONE;
      WRITE:   if (idx == IDX_W'(NUM_LANES - 1)) state_nxt = word_q.last ? DONE : ACCEPT;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: address, byte index, latched word, error flag and word counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      addr         <= '0;
      idx          <= '0;
      word_q       <= '0;
      Load_Error   <= 1'b0;
      Words_Loaded <= '0;
    end else begin
      case (state)
        IDLE: if (Load_Start) begin
          addr         <= Load_Base;
          Words_Loaded <= '0;
          Load_Error   <= misaligned;
        end
        ACCEPT: if (Word_Valid) begin
          // Word is consumed even when it does not fit; only the flag records it.
          word_q.data <= Word_Data;
          word_q.last <= Word_Last;
          idx         <= '0;
          if (!fits) Load_Error <= 1'b1;
        end
        WRITE: begin
          idx <= idx + IDX_W'(1);
          if (idx == IDX_W'(NUM_LANES - 1)) begin
            addr         <= addr + 64'd4;
            Words_Loaded <= Words_Loaded + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // One lane per byte of the word; lane g is bits 8g+7:8g, written at addr+g.
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    inst_mem_loader_lane #(
      .VEC_W (VEC_W),
      .IDX_W (IDX_W),
      .LANE  (g)
    ) u_lane (
      .idx      (idx),
      .data     (word_q.data[g]),
      .sel_byte (lane_byte[g])
    );
  end

  // Outputs decoded from state; address/data held at zero outside WRITE.
  always_comb begin
    Word_Ready  = (state == ACCEPT);
    Mem_Wr_En   = (state == WRITE);
    Load_Busy   = (state == ACCEPT) || (state == WRITE);
    Load_Done   = (state == DONE);
    Mem_Wr_Addr = '0;
    Mem_Wr_Byte = '0;
    if (state == WRITE) begin
      Mem_Wr_Addr = addr + 64'(idx);
      for (int l = 0; l < NUM_LANES; l++) Mem_Wr_Byte = Mem_Wr_Byte | lane_byte[l];
    end
  end
endmodule

// File: tb/tb_inst_mem_loader.sv
module tb_inst_mem_loader;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        Load_Start = 1'b0;
  logic [63:0] Load_Base = '0;
  logic        Word_Valid = 1'b0;
  logic [31:0] Word_Data = '0;
  logic        Word_Last = 1'b0;
  logic        Word_Ready, Mem_Wr_En, Load_Busy, Load_Done, Load_Error;
  logic [63:0] Mem_Wr_Addr;
  logic [7:0]  Mem_Wr_Byte;
  logic [15:0] Words_Loaded;

  inst_mem_loader #(.MEM_BYTES(96), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .Load_Start(Load_Start), .Load_Base(Load_Base),
    .Word_Valid(Word_Valid), .Word_Data(Word_Data), .Word_Last(Word_Last),
    .Word_Ready(Word_Ready), .Mem_Wr_En(Mem_Wr_En), .Mem_Wr_Addr(Mem_Wr_Addr),
    .Mem_Wr_Byte(Mem_Wr_Byte), .Load_Busy(Load_Busy), .Load_Done(Load_Done),
    .Load_Error(Load_Error), .Words_Loaded(Words_Loaded)
  );

  always #5 clk = ~clk;

  // Bench-side instruction memory fed by the DUT's byte write port.
  logic [7:0] mem [0:95];
  int wr_cnt = 0;
  int oob_cnt = 0;
  always @(negedge clk) begin
    if (Mem_Wr_En === 1'b1) begin
      wr_cnt++;
      if (Mem_Wr_Addr < 64'd96) mem[int'(Mem_Wr_Addr)] = Mem_Wr_Byte;
      else oob_cnt++;
    end
  end

  function automatic logic [31:0] rd_word(int a);
    return {mem[a+3], mem[a+2], mem[a+1], mem[a]};
  endfunction

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        start;
    logic [63:0] base;
    logic        valid;
    logic [31:0] data;
    logic        last;
    logic        rdy, en;
    logic [63:0] addr;
    logic [7:0]  byt;
    logic        busy, done, err;
    logic [15:0] words;
  } vec_t;

  vec_t vq[$];

  task automatic add(logic st, logic [63:0] b, logic v, logic [31:0] d, logic l,
                     logic rdy, logic en, logic [63:0] a, logic [7:0] y,
                     logic busy, logic done, logic err, logic [15:0] w);
    vec_t t;
    t.start = st; t.base = b; t.valid = v; t.data = d; t.last = l;
    t.rdy = rdy; t.en = en; t.addr = a; t.byt = y;
    t.busy = busy; t.done = done; t.err = err; t.words = w;
    vq.push_back(t);
  endtask

  initial begin
    int nb, n0;

    // Inputs applied, one clock, then outputs expected after that edge.
    // Two-word load at base 0; Word_Valid during WRITE must be ignored.
    add(1, 0, 0, 0, 0,                1, 0, 0, 8'h00, 1, 0, 0, 0);
    add(0, 0, 1, 32'h10000513, 0,     0, 1, 0, 8'h13, 1, 0, 0, 0);
    add(0, 0, 1, 32'hDEADBEEF, 1,     0, 1, 1, 8'h05, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0,                0, 1, 2, 8'h00, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0,                0, 1, 3, 8'h10, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0,                1, 0, 0, 8'h00, 1, 0, 0, 1);
    add(0, 0, 1, 32'h00500293, 1,     0, 1, 4, 8'h93, 1, 0, 0, 1);
    add(0, 0, 0, 0, 0,                0, 1, 5, 8'h02, 1, 0, 0, 1);
    add(0, 0, 0, 0, 0,                0, 1, 6, 8'h50, 1, 0, 0, 1);
    add(0, 0, 0, 0, 0,                0, 1, 7, 8'h00, 1, 0, 0, 1);
    add(0, 0, 0, 0, 0,                0, 0, 0, 8'h00, 0, 1, 0, 2);
    add(0, 0, 0, 0, 0,                0, 0, 0, 8'h00, 0, 0, 0, 2);
    // Misaligned base: straight to DONE with error, then restart at 0 clears it.
    add(1, 2, 0, 0, 0,                0, 0, 0, 8'h00, 0, 1, 1, 0);
    add(0, 0, 1, 32'h12345678, 0,     0, 0, 0, 8'h00, 0, 0, 1, 0);
    add(1, 0, 0, 0, 0,                1, 0, 0, 8'h00, 1, 0, 0, 0);
    add(0, 0, 1, 32'h10000513, 1,     0, 1, 0, 8'h13, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0,                0, 1, 1, 8'h05, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0,                0, 1, 2, 8'h00, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0,                0, 1, 3, 8'h10, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0,                0, 0, 0, 8'h00, 0, 1, 0, 1);
    add(0, 0, 0, 0, 0,                0, 0, 0, 8'h00, 0, 0, 0, 1);
    // Overflow: 92..95 is the last legal word, the next one is dropped.
    add(1, 92, 0, 0, 0,               1, 0, 0, 8'h00, 1, 0, 0, 0);
    add(0, 0, 1, 32'hAABBCCDD, 0,     0, 1, 92, 8'hDD, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0,                0, 1, 93, 8'hCC, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0,                0, 1, 94, 8'hBB, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0,                0, 1, 95, 8'hAA, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0,                1, 0, 0, 8'h00, 1, 0, 0, 1);
    add(0, 0, 1, 32'h11223344, 1,     0, 0, 0, 8'h00, 0, 1, 1, 1);
    add(0, 0, 0, 0, 0,                0, 0, 0, 8'h00, 0, 0, 1, 1);

    // Reset held 3 cycles with traffic on the inputs: everything stays quiet.
    reset = 1'b0; Word_Valid = 1'b1; Load_Start = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("rst%0d_ready", c), Word_Ready, 0);
      chk($sformatf("rst%0d_en", c), Mem_Wr_En, 0);
      chk($sformatf("rst%0d_addr", c), Mem_Wr_Addr, 0);
      chk($sformatf("rst%0d_byte", c), Mem_Wr_Byte, 0);
      chk($sformatf("rst%0d_busy", c), Load_Busy, 0);
      chk($sformatf("rst%0d_done", c), Load_Done, 0);
      chk($sformatf("rst%0d_err", c), Load_Error, 0);
      chk($sformatf("rst%0d_words", c), Words_Loaded, 0);
    end
    Word_Valid = 1'b0; Load_Start = 1'b0;
    reset = 1'b1;
    step();
    chk("rst_writes", wr_cnt, 0);

    // Table-driven sequences.
    foreach (vq[i]) begin
      Load_Start = vq[i].start; Load_Base = vq[i].base;
      Word_Valid = vq[i].valid; Word_Data = vq[i].data; Word_Last = vq[i].last;
      step();
      chk($sformatf("v%0d_ready", i), Word_Ready, vq[i].rdy);
      chk($sformatf("v%0d_en", i), Mem_Wr_En, vq[i].en);
      chk($sformatf("v%0d_busy", i), Load_Busy, vq[i].busy);
      chk($sformatf("v%0d_done", i), Load_Done, vq[i].done);
      chk($sformatf("v%0d_err", i), Load_Error, vq[i].err);
      chk($sformatf("v%0d_words", i), Words_Loaded, vq[i].words);
      if (vq[i].en) begin
        chk($sformatf("v%0d_addr", i), Mem_Wr_Addr, vq[i].addr);
        chk($sformatf("v%0d_byte", i), Mem_Wr_Byte, vq[i].byt);
      end
    end
    Load_Start = 1'b0; Word_Valid = 1'b0; Word_Last = 1'b0;
    step();
    chk("mem_w0", rd_word(0), 32'h10000513);
    chk("mem_w4", rd_word(4), 32'h00500293);
    chk("mem_w92", rd_word(92), 32'hAABBCCDD);
    chk("oob_writes", oob_cnt, 0);

    // Backpressure: ACCEPT waits indefinitely, then one word = 4 writes.
    nb = wr_cnt;
    Load_Start = 1'b1; Load_Base = 64'd8;
    step();
    Load_Start = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      chk($sformatf("bp%0d_ready", c), Word_Ready, 1);
      chk($sformatf("bp%0d_en", c), Mem_Wr_En, 0);
    end
    chk("bp_idle_writes", wr_cnt - nb, 0);
    Word_Valid = 1'b1; Word_Data = 32'h0BADC0DE; Word_Last = 1'b0;
    step();
    Word_Valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("bp_wr%0d_ready", c), Word_Ready, 0);
      chk($sformatf("bp_wr%0d_addr", c), Mem_Wr_Addr, 64'd8 + 64'(c));
      step();
    end
    chk("bp_ready_back", Word_Ready, 1);
    chk("bp_words", Words_Loaded, 1);
    chk("bp_writes", wr_cnt - nb, 4);
    chk("bp_mem", rd_word(8), 32'h0BADC0DE);
    Word_Valid = 1'b1; Word_Data = 32'h00000013; Word_Last = 1'b1;
    step();
    Word_Valid = 1'b0; Word_Last = 1'b0;
    for (int c = 0; c < 4; c++) step();
    chk("bp_done", Load_Done, 1);
    chk("bp_words2", Words_Loaded, 2);

    // Reset mid-WRITE after byte idx 1; Load_Start during WRITE ignored.
    step();
    nb = wr_cnt;
    Load_Start = 1'b1; Load_Base = 64'd0;
    step();
    Load_Start = 1'b0;
    Word_Valid = 1'b1; Word_Data = 32'hCAFEF00D; Word_Last = 1'b1;
    step();
    Word_Valid = 1'b0; Word_Last = 1'b0;
    chk("mid_b0", Mem_Wr_Byte, 8'h0D);
    Load_Start = 1'b1; Load_Base = 64'h40;
    step();
    Load_Start = 1'b0;
    chk("mid_start_ign_en", Mem_Wr_En, 1);
    chk("mid_start_ign_addr", Mem_Wr_Addr, 1);
    chk("mid_b1", Mem_Wr_Byte, 8'hF0);
    reset = 1'b0;
    step();
    n0 = wr_cnt;
    chk("mid_pre_writes", n0 - nb, 2);
    chk("mid_rst_en", Mem_Wr_En, 0);
    chk("mid_rst_busy", Load_Busy, 0);
    step();
    reset = 1'b1;
    for (int c = 0; c < 3; c++) step();
    chk("mid_post_writes", wr_cnt - n0, 0);
    chk("mid_post_words", Words_Loaded, 0);
    chk("mid_post_done", Load_Done, 0);

    // Fresh load after the aborted one.
    Load_Start = 1'b1; Load_Base = 64'd0;
    step();
    Load_Start = 1'b0;
    Word_Valid = 1'b1; Word_Data = 32'h00500293; Word_Last = 1'b1;
    step();
    Word_Valid = 1'b0; Word_Last = 1'b0;
    for (int c = 0; c < 4; c++) step();
    chk("new_done", Load_Done, 1);
    chk("new_err", Load_Error, 0);
    chk("new_words", Words_Loaded, 1);
    chk("new_mem", rd_word(0), 32'h00500293);
    step();
    chk("new_done_pulse", Load_Done, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
